alu_param_seq: RTL

ALU_PARAM_SEQ -- requirements
Module: alu_param_seq

---
 rtl/alu_param_seq.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_param_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_param_seq                                                   |
// | Purpose  : Registered ALU. Single-cycle logic/arithmetic ops and a         |
// |            multi-cycle shift-add unsigned multiply.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_param_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       select_line,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             out_valid,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             err
);

    localparam int                 c_MSB      = WIDTH - 1;
    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH:0]     c_ONE_EXT  = (WIDTH + 1)'(1);
    localparam bit                 c_MUL_ON   = (MUL_EN != 0);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_NOT = 4'b0101;
    localparam logic [3:0] c_OP_SHL = 4'b0110;
    localparam logic [3:0] c_OP_SHR = 4'b0111;
    localparam logic [3:0] c_OP_INC = 4'b1000;
    localparam logic [3:0] c_OP_DEC = 4'b1001;
    localparam logic [3:0] c_OP_CMP = 4'b1010;
    localparam logic [3:0] c_OP_ADC = 4'b1011;
    localparam logic [3:0] c_OP_MUL = 4'b1100;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic             r_err;

    logic             w_accept;

    // Single-cycle datapath
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_alu_legal;
    logic             w_op_mul;
    logic             w_op_cmp;

    // Multiplier datapath
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [c_CNT_W-1:0] r_mul_cnt;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_upper_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH-1:0]   w_prod_hi;
    logic [WIDTH-1:0]   w_prod_lo;
    logic               w_mul_last;

    assign in_ready      = (r_state == ST_IDLE);
    assign w_accept      = in_valid && in_ready;

    assign result        = r_result;
    assign result_hi     = r_result_hi;
    assign out_valid     = r_out_valid;
    assign zero_flag     = r_zero;
    assign negative_flag = r_neg;
    assign carry_flag    = r_carry;
    assign overflow_flag = r_ovf;
    assign err           = r_err;

    always_comb begin
        w_ext       = '0;
        w_alu_res   = '0;
        w_alu_c     = 1'b0;
        w_alu_v     = 1'b0;
        w_alu_legal = 1'b1;
        w_op_mul    = 1'b0;
        w_op_cmp    = 1'b0;
        case (select_line)
            c_OP_ADD: begin
                w_ext     = {1'b0, a} + {1'b0, b};
                w_alu_res = w_ext[c_MSB:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (a[c_MSB] == b[c_MSB]) && (w_ext[c_MSB] != a[c_MSB]);
            end
            c_OP_ADC: begin
                w_ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_carry};
                w_alu_res = w_ext[c_MSB:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (a[c_MSB] == b[c_MSB]) && (w_ext[c_MSB] != a[c_MSB]);
            end
            c_OP_SUB, c_OP_CMP: begin
                // Top bit of the extended difference is the borrow.
                w_ext     = {1'b0, a} - {1'b0, b};
                w_alu_res = w_ext[c_MSB:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (a[c_MSB] != b[c_MSB]) && (w_ext[c_MSB] != a[c_MSB]);
                w_op_cmp  = (select_line == c_OP_CMP);
            end
            c_OP_AND: w_alu_res = a & b;
            c_OP_OR:  w_alu_res = a | b;
            c_OP_XOR: w_alu_res = a ^ b;
            c_OP_NOT: w_alu_res = ~a;
            c_OP_SHL: begin
                w_alu_res = {a[c_MSB-1:0], 1'b0};
                w_alu_c   = a[c_MSB];
            end
            c_OP_SHR: begin
                w_alu_res = {1'b0, a[c_MSB:1]};
                w_alu_c   = a[0];
            end
            c_OP_INC: begin
                w_ext     = {1'b0, a} + c_ONE_EXT;
                w_alu_res = w_ext[c_MSB:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = !a[c_MSB] && w_ext[c_MSB];
            end
            c_OP_DEC: begin
                w_ext     = {1'b0, a} - c_ONE_EXT;
                w_alu_res = w_ext[c_MSB:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = a[c_MSB] && !w_ext[c_MSB];
            end
            c_OP_MUL: begin
                if (c_MUL_ON) begin
                    w_op_mul = 1'b1;
                end else begin
                    w_alu_legal = 1'b0;
                end
            end
            default: w_alu_legal = 1'b0;
        endcase
    end

    // Right-shifting shift-add: the product register starts as {0, b};
    // the multiplier bits drain out the bottom as the partial sum fills the top.
    assign w_addend    = r_prod[0] ? {1'b0, r_mcand} : '0;
    assign w_upper_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_prod_next = {w_upper_sum, r_prod[WIDTH-1:1]};
    assign w_prod_hi   = w_prod_next[2*WIDTH-1:WIDTH];
    assign w_prod_lo   = w_prod_next[WIDTH-1:0];
    assign w_mul_last  = (r_state == ST_MUL_BUSY) && (r_mul_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_op_mul) begin
                    w_state_next = ST_MUL_BUSY;
                end
            end
            ST_MUL_BUSY: begin
                if (r_mul_cnt == c_CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_prod    <= '0;
            r_mul_cnt <= '0;
        end else if (w_accept && w_op_mul) begin
            r_mcand   <= a;
            r_prod    <= {{WIDTH{1'b0}}, b};
            r_mul_cnt <= '0;
        end else if (r_state == ST_MUL_BUSY) begin
            r_prod    <= w_prod_next;
            r_mul_cnt <= r_mul_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_op_mul) begin
                r_out_valid <= 1'b1;
                if (!w_alu_legal) begin
                    // Flags deliberately left untouched.
                    r_err       <= 1'b1;
                    r_result    <= '0;
                    r_result_hi <= '0;
                end else begin
                    r_err   <= 1'b0;
                    r_zero  <= (w_alu_res == '0);
                    r_neg   <= w_alu_res[c_MSB];
                    r_carry <= w_alu_c;
                    r_ovf   <= w_alu_v;
                    if (!w_op_cmp) begin
                        r_result    <= w_alu_res;
                        r_result_hi <= '0;
                    end
                end
            end else if (w_mul_last) begin
                r_out_valid <= 1'b1;
                r_err       <= 1'b0;
                r_result    <= w_prod_lo;
                r_result_hi <= w_prod_hi;
                r_zero      <= (w_prod_lo == '0) && (w_prod_hi == '0);
                r_neg       <= w_prod_hi[c_MSB];
                r_carry     <= (w_prod_hi != '0);
                r_ovf       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
